// File: rtl/tdm_synth_pkg.sv
// Shared types and constants for the TDM wavetable synth: wave-select codes,
// scheduler FSM encoding and the table read path widths.
package tdm_synth_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned SAMPLE_W = 16;

    localparam logic [1:0] WAVE_SIN = 2'd0;
    localparam logic [1:0] WAVE_TRI = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;
    localparam logic [1:0] WAVE_SAW = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAccum,
        StOut
    } sched_state_e;

endpackage

// File: rtl/voice_param_bank.sv
// Per-voice register file: config write port, slot read port, phase update port.
// Gain registers exist only when VOICE_GAIN_EN is defined.
module voice_param_bank
    import tdm_synth_pkg::*;
#(
    parameter int unsigned VOICES      = 8,
    parameter int unsigned VOICES_BITS = 3,
    parameter int unsigned PHASE_W     = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [VOICES_BITS-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]     cfg_inc,
    input  logic [1:0]             cfg_wave,
    input  logic                   cfg_en,
    input  logic [7:0]             cfg_gain,
    input  logic [VOICES_BITS-1:0] slot,
    output logic [PHASE_W-1:0]     slot_phase,
    output logic [PHASE_W-1:0]     slot_inc,
    output logic [1:0]             slot_wave,
    output logic                   slot_en,
    output logic [7:0]             slot_gain,
    input  logic                   phase_we,
    input  logic [PHASE_W-1:0]     phase_new
);

    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] inc_q   [VOICES];
    logic [1:0]         wave_q  [VOICES];
    logic               en_q    [VOICES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < int'(VOICES); v++) begin
                inc_q[v]  <= '0;
                wave_q[v] <= WAVE_SIN;
                en_q[v]   <= 1'b0;
            end
        end else if (cfg_we) begin
            inc_q[cfg_voice]  <= cfg_inc;
            wave_q[cfg_voice] <= cfg_wave;
            en_q[cfg_voice]   <= cfg_en;
        end
    end

    // Phase is only ever written by the scheduler, so it never races a config write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < int'(VOICES); v++) begin
                phase_q[v] <= '0;
            end
        end else if (phase_we) begin
            phase_q[slot] <= phase_new;
        end
    end

    assign slot_phase = phase_q[slot];
    assign slot_inc   = inc_q[slot];
    assign slot_wave  = wave_q[slot];
    assign slot_en    = en_q[slot];

`ifdef VOICE_GAIN_EN
    logic [7:0] gain_q [VOICES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < int'(VOICES); v++) begin
                gain_q[v] <= '0;
            end
        end else if (cfg_we) begin
            gain_q[cfg_voice] <= cfg_gain;
        end
    end

    assign slot_gain = gain_q[slot];
`else
    logic unused_gain;
    assign unused_gain = ^cfg_gain;
    assign slot_gain   = '0;
`endif

endmodule

// File: rtl/tdm_voice_scheduler.sv
// Round-robin voice scheduler sharing one wavetable read path; one mixed sample per tick.
// Optional per-voice gain scaling is enabled by defining VOICE_GAIN_EN.
module tdm_voice_scheduler
    import tdm_synth_pkg::*;
#(
    parameter int unsigned D_W         = 16,
    parameter int unsigned VOICES      = 8,
    parameter int unsigned VOICES_BITS = 3,
    parameter int unsigned PHASE_W     = 24,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic [VOICES_BITS-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]     cfg_inc,
    input  logic [1:0]             cfg_wave,
    input  logic                   cfg_en,
    input  logic [7:0]             cfg_gain,
    output logic                   wt_req,
    output logic [ADDR_W-1:0]      wt_addr,
    output logic [1:0]             wt_wave_sel,
    input  logic [D_W-1:0]         wt_sample,
    output logic [D_W-1:0]         mix_out,
    output logic                   mix_valid,
    input  logic                   mix_ready,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned ACC_W = D_W + VOICES_BITS;
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    sched_state_e             state;
    logic [VOICES_BITS-1:0]   slot;
    logic [CNT_W-1:0]         wait_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  contrib;
    logic                     tick_pend;
    logic                     tick_drop;

    logic [PHASE_W-1:0] slot_phase;
    logic [PHASE_W-1:0] slot_inc;
    logic [1:0]         slot_wave;
    logic               slot_en;
    logic [7:0]         slot_gain;
    logic               phase_we;
    logic [PHASE_W-1:0] phase_new;

    voice_param_bank #(
        .VOICES      (VOICES),
        .VOICES_BITS (VOICES_BITS),
        .PHASE_W     (PHASE_W)
    ) u_bank (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .cfg_we     (cfg_we),
        .cfg_voice  (cfg_voice),
        .cfg_inc    (cfg_inc),
        .cfg_wave   (cfg_wave),
        .cfg_en     (cfg_en),
        .cfg_gain   (cfg_gain),
        .slot       (slot),
        .slot_phase (slot_phase),
        .slot_inc   (slot_inc),
        .slot_wave  (slot_wave),
        .slot_en    (slot_en),
        .slot_gain  (slot_gain),
        .phase_we   (phase_we),
        .phase_new  (phase_new)
    );

    assign phase_we  = (state == StAccum);
    assign phase_new = slot_en ? slot_phase + slot_inc : '0;

    // busy also covers the cycle between accepting a tick and entering the first slot.
    assign tick_drop = sample_tick && (busy || (mix_valid && !mix_ready));

`ifdef VOICE_GAIN_EN
    logic signed [D_W+8:0] prod;
    always_comb begin
        prod    = $signed(wt_sample) * $signed({1'b0, slot_gain});
        contrib = '0;
        if (slot_en) begin
            contrib = ACC_W'(prod >>> 8);
        end
    end
`else
    logic unused_slot_gain;
    assign unused_slot_gain = ^slot_gain;
    always_comb begin
        contrib = '0;
        if (slot_en) begin
            contrib = ACC_W'($signed(wt_sample));
        end
    end
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= StIdle;
            slot        <= '0;
            wait_cnt    <= '0;
            acc         <= '0;
            tick_pend   <= 1'b0;
            wt_req      <= 1'b0;
            wt_addr     <= '0;
            wt_wave_sel <= '0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            wt_req <= 1'b0;
            if (tick_drop) begin
                overrun <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (mix_valid && mix_ready) begin
                        mix_valid <= 1'b0;
                    end
                    if (tick_pend) begin
                        tick_pend <= 1'b0;
                        slot      <= '0;
                        acc       <= '0;
                        state     <= StIssue;
                    end else if (sample_tick && !tick_drop) begin
                        tick_pend <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StIssue: begin
                    if (slot_en) begin
                        wt_req      <= 1'b1;
                        wt_addr     <= slot_phase[PHASE_W-1 -: ADDR_W];
                        wt_wave_sel <= slot_wave;
                    end
                    wait_cnt <= CNT_W'(RD_LAT - 1);
                    state    <= StWait;
                end
                StWait: begin
                    if (wait_cnt == '0) begin
                        state <= StAccum;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StAccum: begin
                    acc <= acc + contrib;
                    if (slot == VOICES_BITS'(VOICES - 1)) begin
                        state <= StOut;
                    end else begin
                        slot  <= slot + 1'b1;
                        state <= StIssue;
                    end
                end
                StOut: begin
                    mix_out   <= acc[ACC_W-1:VOICES_BITS];
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// Directed bench for tdm_voice_scheduler with a latency-accurate table model
// and a scoreboard of expected mixes and table reads.
module tb_tdm_voice_scheduler;

    localparam int D_W     = 16;
    localparam int VOICES  = 8;
    localparam int VB      = 3;
    localparam int PW      = 24;
    localparam int RD_LAT  = 2;
    localparam int LATENCY = VOICES * (RD_LAT + 2) + 2;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            sample_tick;
    logic            cfg_we;
    logic [VB-1:0]   cfg_voice;
    logic [PW-1:0]   cfg_inc;
    logic [1:0]      cfg_wave;
    logic            cfg_en;
    logic [7:0]      cfg_gain;
    logic            wt_req;
    logic [7:0]      wt_addr;
    logic [1:0]      wt_wave_sel;
    logic [D_W-1:0]  wt_sample;
    logic [D_W-1:0]  mix_out;
    logic            mix_valid;
    logic            mix_ready;
    logic            busy;
    logic            overrun;

    always #5 sys_clk = ~sys_clk;

    tdm_voice_scheduler dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_inc     (cfg_inc),
        .cfg_wave    (cfg_wave),
        .cfg_en      (cfg_en),
        .cfg_gain    (cfg_gain),
        .wt_req      (wt_req),
        .wt_addr     (wt_addr),
        .wt_wave_sel (wt_wave_sel),
        .wt_sample   (wt_sample),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .mix_ready   (mix_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Table model: data appears RD_LAT cycles after the request, garbage otherwise.
    int          tbl_mode = 0;
    logic [15:0] tbl_const = 16'h0000;
    logic [15:0] pipe [RD_LAT];

    function automatic logic [15:0] tbl_val(input logic [7:0] a);
        return (tbl_mode == 0) ? {a, 8'h00} : tbl_const;
    endfunction

    always @(posedge sys_clk) begin
        pipe[0] <= wt_req ? tbl_val(wt_addr) : 16'hDEAD;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign wt_sample = pipe[RD_LAT-1];

    logic [9:0] req_q [$];
    always @(negedge sys_clk) if (wt_req) req_q.push_back({wt_wave_sel, wt_addr});

    // Reference model and scoreboard
    logic [PW-1:0] m_phase [VOICES];
    logic [PW-1:0] m_inc   [VOICES];
    logic [1:0]    m_wave  [VOICES];
    logic          m_en    [VOICES];
    logic [15:0]   exp_q   [$];
    logic [9:0]    exp_req [$];
    logic [15:0]   exp_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < VOICES; v++) begin
            m_phase[v] = '0; m_inc[v] = '0; m_wave[v] = '0; m_en[v] = 1'b0;
        end
        exp_q.delete();
        exp_req.delete();
        req_q.delete();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_clear();
        @(negedge sys_clk);
    endtask

    task automatic cfg_write(input int v, input logic [PW-1:0] inc, input logic [1:0] wave,
                             input logic en);
        logic [VB-1:0] vi;
        vi = v[VB-1:0];
        cfg_voice = vi; cfg_inc = inc; cfg_wave = wave; cfg_en = en; cfg_we = 1'b1;
        @(negedge sys_clk);
        cfg_we = 1'b0;
        m_inc[v] = inc; m_wave[v] = wave; m_en[v] = en;
    endtask

    task automatic start_frame();
        int acc;
        logic [7:0]  a;
        logic [15:0] s;
        logic [15:0] e;
        acc = 0;
        exp_req.delete();
        req_q.delete();
        for (int v = 0; v < VOICES; v++) begin
            if (m_en[v]) begin
                a = m_phase[v][PW-1 -: 8];
                s = tbl_val(a);
                acc += $signed(s);
                exp_req.push_back({m_wave[v], a});
                m_phase[v] = m_phase[v] + m_inc[v];
            end else begin
                m_phase[v] = '0;
            end
        end
        acc = acc >>> VB;
        e = acc[15:0];
        exp_q.push_back(e);
        sample_tick = 1'b1;
        @(negedge sys_clk);
        sample_tick = 1'b0;
        tick_cyc = cyc;
    endtask

    task automatic wait_mix(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 200 && !mix_valid; i++) @(negedge sys_clk);
        check({tag, "_valid"}, 32'(mix_valid), 32'd1);
        check({tag, "_latency"}, 32'(cyc - tick_cyc), 32'(LATENCY));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        exp_last = e;
        check({tag, "_mix"}, 32'(mix_out), 32'(e));
        check({tag, "_nreq"}, 32'(req_q.size()), 32'(exp_req.size()));
        for (int i = 0; i < exp_req.size() && i < req_q.size(); i++)
            check({tag, "_req"}, 32'(req_q[i]), 32'(exp_req[i]));
    endtask

    initial begin
        int seen;
        sys_rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_inc = '0;
        cfg_wave = '0; cfg_en = 1'b0; cfg_gain = '0; mix_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge sys_clk);
        check("rst_mix_out", 32'(mix_out), 32'd0);
        check("rst_mix_valid", 32'(mix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_wt_req", 32'(wt_req), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single voice, ramp of addresses 0,1,2
        cfg_write(0, 24'h010000, 2'd0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            start_frame();
            check("single_busy", 32'(busy), 32'd1);
            wait_mix("single");
            @(negedge sys_clk);
            check("single_drop", 32'(mix_valid), 32'd0);
        end

        // Tick on the same cycle as the accepting handshake
        mix_ready = 1'b0;
        start_frame();
        wait_mix("hold");
        mix_ready = 1'b1;
        start_frame();
        check("coinc_valid_drop", 32'(mix_valid), 32'd0);
        check("coinc_busy", 32'(busy), 32'd1);
        check("coinc_overrun", 32'(overrun), 32'd0);
        wait_mix("coinc");
        @(negedge sys_clk);

        // Backpressure: dropped tick sets overrun, output holds
        mix_ready = 1'b0;
        start_frame();
        wait_mix("bp");
        sample_tick = 1'b1;
        @(negedge sys_clk);
        sample_tick = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_hold_valid", 32'(mix_valid), 32'd1);
        check("bp_hold_mix", 32'(mix_out), 32'(exp_last));
        check("bp_no_frame", 32'(busy), 32'd0);
        mix_ready = 1'b1;
        @(negedge sys_clk);
        check("bp_release", 32'(mix_valid), 32'd0);

        // Full-scale mixes with all voices enabled
        do_reset();
        check("rst_clears_overrun", 32'(overrun), 32'd0);
        for (int v = 0; v < VOICES; v++) begin
            logic [PW-1:0] inc;
            inc = PW'(v * 24'h031234 + 24'h000100);
            cfg_write(v, inc, 2'(v % 4), 1'b1);
        end
        tbl_mode = 1; tbl_const = 16'h7FFF;
        start_frame();
        wait_mix("full_pos");
        check("full_pos_value", 32'(mix_out), 32'h7FFF);
        @(negedge sys_clk);
        tbl_const = 16'h8000;
        start_frame();
        wait_mix("full_neg");
        check("full_neg_value", 32'(mix_out), 32'h8000);
        @(negedge sys_clk);
        tbl_mode = 0;
        cfg_write(5, 24'h000000, 2'd2, 1'b0);
        start_frame();
        wait_mix("mixed");
        @(negedge sys_clk);

        // Phase wrap-around
        do_reset();
        cfg_write(0, 24'hFFFFFF, 2'd3, 1'b1);
        for (int f = 0; f < 3; f++) begin
            start_frame();
            wait_mix("wrap");
            @(negedge sys_clk);
        end

        // Reset during voice 4 WAIT discards the frame
        do_reset();
        for (int v = 0; v < VOICES; v++) cfg_write(v, 24'h010000, 2'd1, 1'b1);
        start_frame();
        wait_mix("pre_abort");
        @(negedge sys_clk);
        start_frame();
        repeat (18) @(negedge sys_clk);
        check("abort_busy", 32'(busy), 32'd1);
        do_reset();
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (mix_valid) seen++;
            @(negedge sys_clk);
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        for (int v = 0; v < VOICES; v++) cfg_write(v, 24'h010000, 2'd1, 1'b1);
        start_frame();
        wait_mix("post_abort");
        @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_voice_scheduler.md
Name: tdm_voice_scheduler

Overview:
Time-division scheduler that shares the single wavetable read path (four 16x256 fix14_16 tables, 2-bit wave select, 8-bit address) among VOICES oscillators.
- On each audio sample tick it walks all voices round-robin.
- For each voice it advances the voice's phase accumulator, issues one table read, captures the returned sample and accumulates it into a mix.
- It presents one mixed sample per tick to the downstream DSP/output stage through a valid/ready handshake.
- It sits between the control/config logic and the wavetable read interface.

Parameters:
- D_W, 16, sample width (signed fix14_16, bounded +/-1).
- VOICES, 8, number of voices; power of two.
- VOICES_BITS, 3, log2(VOICES).
- PHASE_W, 24, phase accumulator width; table address = phase[PHASE_W-1 -: 8].
- RD_LAT, 2, fixed cycles from wt_req to wt_sample valid; >=1.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- sample_tick  in  1  one-cycle pulse that starts a frame.
- cfg_we  in  1  config write strobe.
- cfg_voice  in  VOICES_BITS  voice index to write.
- cfg_inc  in  PHASE_W  phase increment.
- cfg_wave  in  2  wave select: 0 sin, 1 tri, 2 sqr, 3 saw.
- cfg_en  in  1  voice enable.
- cfg_gain  in  8  per-voice gain; ignored unless VOICE_GAIN_EN.
- wt_req  out  1  table read strobe.
- wt_addr  out  8  table address.
- wt_wave_sel  out  2  table select.
- wt_sample  in  D_W  table read data, valid RD_LAT cycles after wt_req.
- mix_out  out  D_W  mixed sample.
- mix_valid  out  1  mix_out valid.
- mix_ready  in  1  downstream accept.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a tick was dropped.

Behaviour:
- Reset values:
  - Outputs: all 0.
  - Per voice: phase, inc, wave, en, gain all 0.
  - Accumulator 0; state IDLE; slot counter 0.
- Reset applies immediately, including mid-frame. The in-progress frame is discarded and no mix_valid is produced.
- FSM states and transitions:
  - IDLE: on sample_tick with mix_valid=0 -> ISSUE, with slot=0 and accumulator cleared. busy=1 from the next cycle.
  - ISSUE (1 cycle):
    - If en[slot]=1: wt_req=1, wt_addr=phase[slot][PHASE_W-1 -: 8], wt_wave_sel=wave[slot].
    - If en[slot]=0: wt_req=0 and the voice contributes 0.
  - WAIT (RD_LAT cycles): down-counter.
  - ACCUM (1 cycle):
    - acc += sign-extended wt_sample, or 0 if the voice is disabled.
    - phase[slot] += inc[slot] mod 2^PHASE_W; a disabled voice's phase is forced to 0.
    - If slot==VOICES-1 -> OUT, else slot+1 -> ISSUE.
  - OUT (1 cycle): mix_out = acc >>> VOICES_BITS (arithmetic, truncating); mix_valid=1; busy=0 -> IDLE.
- Accumulator width is D_W+VOICES_BITS, signed. It cannot overflow.
- Latency: mix_valid rises exactly VOICES*(RD_LAT+2)+2 cycles after the edge that samples sample_tick. Disabled voices still consume their slot, so latency is constant.
- Handshake:
  - mix_out and mix_valid hold until the cycle where mix_valid&&mix_ready; mix_valid drops on the next edge.
  - mix_out never changes while mix_valid=1.
- Tick while busy, or while mix_valid=1 and unaccepted: the tick is dropped and overrun is set (sticky until reset).
- Tick on the same cycle as the accepting handshake: the frame starts; no overrun.
- Config writes are accepted any cycle and written on the next edge:
  - Each voice uses the values held at its own ISSUE/ACCUM cycles.
  - A write to the voice currently in WAIT/ACCUM affects that voice's phase update in the same frame.
  - Writing en=0 clears that voice's phase on its next ACCUM.
- Phase wrap-around is natural modulo 2^PHASE_W, with no flag.

Optional Feature:
- Macro: VOICE_GAIN_EN.
- Defined:
  - ACCUM adds (wt_sample * gain[slot]) >>> 8, computed as a signed D_W x unsigned 8 product.
  - gain=255 is approximately unity; gain=0 mutes the voice.
  - Gain registers and cfg_gain are live.
- Undefined:
  - Samples are added unscaled.
  - Gain registers are not instantiated and cfg_gain is ignored.
  - Latency is identical in both builds.

Decomposition:
- Package tdm_synth_pkg holds:
  - Wave-select codes (WAVE_SIN=0, WAVE_TRI=1, WAVE_SQR=2, WAVE_SAW=3).
  - FSM state encoding.
  - Table address width 8 and sample width 16.
- One sub-module, voice_param_bank: per-voice inc/phase/wave/en/gain register file with a config write port, a slot read port and a phase-update port.

Test Plan:
- Single voice: voice0 en=1, inc=0x010000, wave=0; table model returns {addr,8'h00}; 3 ticks -> wt_addr 0x00, 0x01, 0x02; mix_out = sample>>>3, i.e. 0x0000, 0x0020, 0x0040.
- Latency: VOICES=8, RD_LAT=2; tick at cycle 10 -> mix_valid first high at cycle 44; wt_req pulses only in enabled slots.
- Backpressure: hold mix_ready=0, send a second tick -> overrun=1, mix_out unchanged; release ready -> mix_valid drops next cycle.
- Full-scale mix: all 8 voices enabled, table returns 0x7FFF -> mix_out=0x7FFF; table returns 0x8000 -> mix_out=0x8000, no overflow.
- Wrap: inc=0xFFFFFF, phase 0 -> after one frame phase=0xFFFFFF (addr 0xFF), after the next frame 0xFFFFFE.
- Reset mid-frame: assert sys_rst during voice 4 WAIT -> no mix_valid; all phases 0; next tick produces a clean frame.
